// File: rtl/decision_count.sv
// Classifies the frequency of an asynchronous square wave by counting its rising
// edges over fixed windows. A class is confirmed once two consecutive windows agree.
module decision_count #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int WINDOW_CYCLES = 10_000_000,
  parameter int TH1           = 10,
  parameter int TH2           = 60,
  parameter int TH3           = 300,
  parameter int TH4           = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blinky,
  output logic [2:0] finalAnswer,
  output logic       finalDone,
  output logic [4:0] lightOut
);

  // The window length is WINDOW_CYCLES / CLK_HZ seconds; the counter is only 24 bits wide.
  if (CLK_HZ < 1 || WINDOW_CYCLES < 2 || WINDOW_CYCLES > (1 << 24)) begin : g_bad_param
    $error("decision_count: bad CLK_HZ or WINDOW_CYCLES");
  end

  localparam logic [23:0] WIN_LAST = 24'(WINDOW_CYCLES - 1);
  localparam logic [10:0] T1 = 11'(TH1);
  localparam logic [10:0] T2 = 11'(TH2);
  localparam logic [10:0] T3 = 11'(TH3);
  localparam logic [10:0] T4 = 11'(TH4);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  logic [1:0]  sync_q, sync_d;
  logic        dly_q, dly_d;
  logic [23:0] win_q, win_d;
  logic [9:0]  edge_q, edge_d;
  logic [2:0]  prev_q, prev_d;
  logic        seen_q, seen_d;
  logic [2:0]  ans_q, ans_d;
  logic        done_q, done_d;
  logic [4:0]  light_q, light_d;

  logic        rise, win_end;
  logic [9:0]  cnt_inc;
  logic [2:0]  cls;

  always_comb begin
    rise    = sync_q[1] & ~dly_q;
    win_end = (win_q == WIN_LAST);
    // An edge on the window-end cycle still belongs to the ending window.
    cnt_inc = (rise && edge_q != CNT_MAX) ? edge_q + 10'd1 : edge_q;

    if      ({1'b0, cnt_inc} < T1) cls = 3'd0;
    else if ({1'b0, cnt_inc} < T2) cls = 3'd1;
    else if ({1'b0, cnt_inc} < T3) cls = 3'd2;
    else if ({1'b0, cnt_inc} < T4) cls = 3'd3;
    else                           cls = 3'd4;

    sync_d  = {sync_q[0], blinky};
    dly_d   = sync_q[1];
    win_d   = win_end ? 24'd0 : win_q + 24'd1;
    edge_d  = win_end ? 10'd0 : cnt_inc;
    prev_d  = prev_q;
    seen_d  = seen_q;
    ans_d   = ans_q;
    done_d  = done_q;
    light_d = light_q;

    if (win_end) begin
      light_d = 5'b00001 << cls;
      prev_d  = cls;
      seen_d  = 1'b1;
      if (seen_q && cls == prev_q) begin
        ans_d  = cls;
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      win_q   <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      seen_q  <= 1'b0;
      ans_q   <= '0;
      done_q  <= 1'b0;
      light_q <= '0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      win_q   <= win_d;
      edge_q  <= edge_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
      light_q <= light_d;
    end
  end

  assign finalAnswer = ans_q;
  assign finalDone   = done_q;
  assign lightOut    = light_q;

endmodule

// File: tb/tb_decision_count.sv
// Directed bench for decision_count with a short window; each window carries a known
// number of rising edges placed clear of the window boundary unless a tail edge is asked for.
module tb_decision_count;

  localparam int W = 2400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blinky = 1'b0;
  logic [2:0] finalAnswer;
  logic       finalDone;
  logic [4:0] lightOut;

  int n_chk = 0;
  int n_err = 0;

  decision_count #(.CLK_HZ(100_000_000), .WINDOW_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .blinky(blinky),
    .finalAnswer(finalAnswer), .finalDone(finalDone), .lightOut(lightOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n pulses of period p starting at cycle 1; tail adds a rise the synchronizer
  // delivers exactly on the window-end cycle; hi holds blinky high from cycle 1.
  function automatic logic pat(input int k, input int n, input int p,
                               input bit tail, input bit hi);
    if (hi) return k >= 1;
    if (tail && k >= W - 3) return 1'b1;
    if (k >= 1 && k < 1 + n * p && ((k - 1) % p) < p / 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run(input int n, input int p, input int ncyc,
                     input bit tail = 1'b0, input bit hi = 1'b0);
    for (int k = 0; k < ncyc; k++) begin
      blinky = pat(k, n, p, tail, hi);
      @(negedge clk);
    end
  endtask

  task automatic win(input string tag, input int n, input int p, input int light,
                     input int ans, input int done, input bit tail = 1'b0,
                     input bit hi = 1'b0);
    run(n, p, W, tail, hi);
    check({tag, ".light"}, int'(lightOut), light);
    check({tag, ".ans"}, int'(finalAnswer), ans);
    check({tag, ".done"}, int'(finalDone), done);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.light", int'(lightOut), 0);
    check("rst.ans", int'(finalAnswer), 0);
    check("rst.done", int'(finalDone), 0);
    rst = 1'b0;

    win("c1a",   10,  20, 5'b00010, 0, 0);
    win("c1b59", 59,  20, 5'b00010, 1, 1);
    win("tail60", 59, 20, 5'b00100, 1, 0, 1'b1);
    win("c2b",   60,  20, 5'b00100, 2, 1);
    win("c3a",   500,  4, 5'b01000, 2, 0);
    win("c3b",   500,  4, 5'b01000, 3, 1);
    win("c4a",   694,  3, 5'b10000, 3, 0);
    win("c4b",   694,  3, 5'b10000, 4, 1);
    win("sat",   1195, 2, 5'b10000, 4, 1);
    win("c0a9",  9,   20, 5'b00001, 4, 0);
    win("hi0",   0,    2, 5'b00001, 0, 1, 1'b0, 1'b1);

    // Heavy partial window, then a one-cycle reset mid-window.
    run(300, 3, 1000);
    check("hold.light", int'(lightOut), 5'b00001);
    blinky = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mrst.light", int'(lightOut), 0);
    check("mrst.ans", int'(finalAnswer), 0);
    check("mrst.done", int'(finalDone), 0);
    rst = 1'b0;
    win("re1", 60, 20, 5'b00100, 0, 0);
    win("re2", 60, 20, 5'b00100, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
